gpio_apb_arb: RTL and testbench

GPIO_APB_ARB -- requirements
Module: gpio_apb_arb

---
 rtl/gpio_pkg.sv | 28 ++
 rtl/gpio_rr_arb.sv | 57 +++++
 rtl/gpio_apb_arb.sv | 102 ++++++++++
 tb/tb_gpio_apb_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO APB arbiter: FSM states, GPIO register
// word offsets and default bus widths.
package gpio_pkg;

  localparam int unsigned GPIO_ADDR_W = 5;
  localparam int unsigned GPIO_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } gpio_state_e;

  // Word offsets (byte offset >> 2) of the GPIO slave registers
  localparam logic [GPIO_ADDR_W-1:0] GPIO_DR            = 5'd0;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_DDR           = 5'd1;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_CTL           = 5'd2;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_INTEN         = 5'd12;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_INTMASK       = 5'd13;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_INTTYPE       = 5'd14;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_POLARITY      = 5'd15;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_INTSTATUS     = 5'd16;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_RAW_INTSTATUS = 5'd17;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_EOI           = 5'd19;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_EXT_PORTA     = 5'd20;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_LS_SYNC       = 5'd24;

endpackage

// File: rtl/gpio_rr_arb.sv
// Two-way round-robin pick with registered last grant and optional grant lock.
// Lock support is compiled in with GPIO_APB_ARB_LOCK_EN.
module gpio_rr_arb (
  input  logic       pclk,
  input  logic       preset,
  input  logic [1:0] req_valid,
  input  logic       take,
  input  logic       ack_done,
  input  logic       ack_lock,
  output logic       gnt_id,
  output logic       pick_c,
  output logic       start_c
);

  logic locked;

`ifdef GPIO_APB_ARB_LOCK_EN
  // Lock follows the lock bit of whichever requester was acked last
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      locked <= 1'b0;
    end else if (ack_done) begin
      locked <= ack_lock;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ack_done & ack_lock;
  assign locked      = 1'b0;
`endif

  always_comb begin
    pick_c  = gnt_id;
    start_c = 1'b0;
    if (locked) begin
      start_c = req_valid[gnt_id];
    end else begin
      start_c = |req_valid;
      case (req_valid)
        2'b01:   pick_c = 1'b0;
        2'b10:   pick_c = 1'b1;
        2'b11:   pick_c = ~gnt_id;
        default: pick_c = gnt_id;
      endcase
    end
  end

  // Reset to 1 so requester 0 wins the first tie
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      gnt_id <= 1'b1;
    end else if (take) begin
      gnt_id <= pick_c;
    end
  end

endmodule

// File: rtl/gpio_apb_arb.sv
// Two-requester APB master front-end for the GPIO slave: fixed 3-cycle transfers.
// Define GPIO_APB_ARB_LOCK_EN to honour reqN_lock (grant stays with the locker).
module gpio_apb_arb
  import gpio_pkg::*;
#(
  parameter int unsigned ADDR_W = GPIO_ADDR_W,
  parameter int unsigned DATA_W = GPIO_DATA_W
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_lock,
  output logic              req0_ack,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_lock,
  output logic              req1_ack,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  output logic              gnt_id,
  output logic              busy
);

  gpio_state_e state, state_next;
  logic        pick_c, start_c, take_c, in_access_c, ack_lock_c;

  assign in_access_c = (state == ST_ACCESS);
  assign take_c      = (state == ST_IDLE) && start_c;
  assign ack_lock_c  = gnt_id ? req1_lock : req0_lock;
  assign req0_ack    = in_access_c && !gnt_id;
  assign req1_ack    = in_access_c &&  gnt_id;

  gpio_rr_arb u_arb (
    .pclk      (pclk),
    .preset    (preset),
    .req_valid ({req1_valid, req0_valid}),
    .take      (take_c),
    .ack_done  (in_access_c),
    .ack_lock  (ack_lock_c),
    .gnt_id    (gnt_id),
    .pick_c    (pick_c),
    .start_c   (start_c)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // No pready on this slave: SETUP and ACCESS always last one cycle each
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start_c) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // APB controls registered from the next state; request captured at grant
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      psel       <= 1'b0;
      penable    <= 1'b0;
      busy       <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      psel    <= (state_next != ST_IDLE);
      penable <= (state_next == ST_ACCESS);
      busy    <= (state_next != ST_IDLE);
      if (take_c) begin
        pwrite <= pick_c ? req1_write : req0_write;
        paddr  <= pick_c ? req1_addr  : req0_addr;
        pwdata <= pick_c ? req1_wdata : req0_wdata;
      end
      if (in_access_c && !pwrite) begin
        if (gnt_id) req1_rdata <= prdata;
        else        req0_rdata <= prdata;
      end
    end
  end

endmodule

// File: tb/tb_gpio_apb_arb.sv
// Randomised and directed bench for gpio_apb_arb against a transaction-level model.
module tb_gpio_apb_arb;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
`ifdef GPIO_APB_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam int M_DROP = 0;
  localparam int M_HOLD = 1;
  localparam int M_LOCK = 2;

  logic          pclk = 1'b0;
  logic          preset = 1'b0;
  logic [1:0]    v_valid, v_write, v_lock;
  logic [AW-1:0] v_addr  [2];
  logic [DW-1:0] v_wdata [2];
  logic          ack0, ack1, psel, penable, pwrite, gnt_id, busy;
  logic [DW-1:0] rd0, rd1, pwdata, prdata;
  logic [AW-1:0] paddr;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model state
  int            cyc, m_s, mode, seq0;
  bit            m_act, m_win, m_gnt, m_locked, m_pwrite;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata;
  logic [DW-1:0] m_rd [2];
  int            order[$];
  int            ack_k[$];
  bit            pr_fixed_en;
  logic [DW-1:0] pr_fixed;

  gpio_apb_arb dut (
    .pclk(pclk), .preset(preset),
    .req0_valid(v_valid[0]), .req0_write(v_write[0]), .req0_addr(v_addr[0]),
    .req0_wdata(v_wdata[0]), .req0_lock(v_lock[0]), .req0_ack(ack0), .req0_rdata(rd0),
    .req1_valid(v_valid[1]), .req1_write(v_write[1]), .req1_addr(v_addr[1]),
    .req1_wdata(v_wdata[1]), .req1_lock(v_lock[1]), .req1_ack(ack1), .req1_rdata(rd1),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 pclk = ~pclk;

  function automatic void check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    cyc = 0; m_act = 0; m_s = 0; m_win = 0; m_gnt = 1; m_locked = 0;
    m_pwrite = 0; m_paddr = '0; m_pwdata = '0; m_rd[0] = '0; m_rd[1] = '0;
  endfunction

  // A transfer started in cycle s is SETUP at s, ACCESS (acked) at s+1, idle at s+2
  function automatic void check_outputs();
    bit s_c, a_c;
    s_c = m_act && (cyc == m_s);
    a_c = m_act && (cyc == m_s + 1);
    check("psel",    psel,    s_c | a_c);
    check("penable", penable, a_c);
    check("busy",    busy,    s_c | a_c);
    check("ack0",    ack0,    a_c && !m_win);
    check("ack1",    ack1,    a_c &&  m_win);
    check("gnt_id",  gnt_id,  m_gnt);
    check("pwrite",  pwrite,  m_pwrite);
    check("paddr",   paddr,   m_paddr);
    check("pwdata",  pwdata,  m_pwdata);
    check("rdata0",  rd0,     m_rd[0]);
    check("rdata1",  rd1,     m_rd[1]);
  endfunction

  function automatic void model_adv();
    logic [1:0] elig;
    bit w;
    if (m_act && cyc == m_s + 1) begin
      if (!m_pwrite) m_rd[m_win] = prdata;
      if (LOCK_EN) m_locked = v_lock[m_win];
    end
    if (!m_act || cyc >= m_s + 2) begin
      elig = v_valid;
      if (m_locked) elig = elig & (m_gnt ? 2'b10 : 2'b01);
      if (elig != 2'b00) begin
        w        = (elig == 2'b11) ? !m_gnt : elig[1];
        m_gnt    = w;
        m_win    = w;
        m_act    = 1;
        m_s      = cyc + 1;
        m_pwrite = v_write[w];
        m_paddr  = v_addr[w];
        m_pwdata = v_wdata[w];
      end
    end
    cyc++;
  endfunction

  task automatic tick(output logic a0, output logic a1);
    @(negedge pclk);
    check_outputs();
    a0 = ack0;
    a1 = ack1;
    @(posedge pclk);
    model_adv();
    #1;
    prdata = pr_fixed_en ? pr_fixed : DW'($urandom);
  endtask

  task automatic do_reset();
    preset = 1'b1;
    #1;
    check("rst_psel",    psel,    1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_acks",    {ack1, ack0}, 2'b00);
    check("rst_gnt",     gnt_id,  1'b1);
    check("rst_bus",     {pwrite, paddr, pwdata}, '0);
    check("rst_rdata",   {rd1, rd0}, '0);
    @(posedge pclk);
    #1;
    preset = 1'b0;
    model_reset();
  endtask

  task automatic set_req(int n, bit wr, logic [AW-1:0] a, logic [DW-1:0] d, bit lk);
    v_valid[n] = 1'b1; v_write[n] = wr; v_addr[n] = a; v_wdata[n] = d; v_lock[n] = lk;
  endtask

  task automatic on_ack(int n, int k);
    order.push_back(n);
    ack_k.push_back(k);
    case (mode)
      M_HOLD: v_addr[n] = AW'($urandom);
      M_LOCK: if (n == 0 && seq0 == 0) begin
                set_req(0, 1'b1, 5'h02, 32'h1234_5678, 1'b0);
                seq0++;
              end else v_valid[n] = 1'b0;
      default: v_valid[n] = 1'b0;
    endcase
  endtask

  task automatic run(int n, int budget);
    logic a0, a1;
    int got = 0;
    order.delete();
    ack_k.delete();
    for (int k = 0; k < budget && got < n; k++) begin
      tick(a0, a1);
      if (a0) begin got++; on_ack(0, k); end
      if (a1) begin got++; on_ack(1, k); end
    end
    check("acks_done", got, n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a0, a1;
    int exp_o [3];
    v_valid = '0; v_write = '0; v_lock = '0;
    v_addr[0] = '0; v_addr[1] = '0; v_wdata[0] = '0; v_wdata[1] = '0;
    prdata = '0; pr_fixed_en = 1'b0; pr_fixed = '0; mode = M_DROP; seq0 = 0;
    model_reset();
    #2;
    do_reset();

    // Lone write from requester 0
    set_req(0, 1'b1, 5'h00, 32'h0000_00A5, 1'b0);
    tick(a0, a1);
    check("w_psel_c1", {psel, penable}, 2'b10);
    tick(a0, a1);
    check("w_pen_c2", {psel, penable}, 2'b11);
    check("w_paddr", paddr, 5'h00);
    check("w_pwdata", pwdata, 32'hA5);
    check("w_ack0_c2", {ack1, ack0}, 2'b01);
    v_valid[0] = 1'b0;
    tick(a0, a1);
    check("w_busy_c3", busy, 1'b0);

    // Read by requester 0, then requester 1 read must not disturb it
    pr_fixed_en = 1'b1;
    pr_fixed = 32'h0000_005A;
    set_req(0, 1'b0, 5'h01, '0, 1'b0);
    run(1, 10);
    pr_fixed = 32'h0000_003C;
    set_req(1, 1'b0, 5'h14, '0, 1'b0);
    run(1, 10);
    check("r1_order", order[0], 1);
    repeat (3) tick(a0, a1);
    check("r1_rdata", rd1, 32'h3C);
    check("r0_rdata_kept", rd0, 32'h5A);
    pr_fixed_en = 1'b0;

    // Both requesters continuously valid: alternate, 3 cycles apart
    do_reset();
    mode = M_HOLD;
    set_req(0, 1'b0, 5'h02, '0, 1'b0);
    set_req(1, 1'b1, 5'h0C, 32'hDEAD_BEEF, 1'b0);
    run(4, 40);
    for (int i = 0; i < 4; i++) check("rr_order", order[i], i % 2);
    for (int i = 1; i < 4; i++) check("rr_spacing", ack_k[i] - ack_k[i-1], 3);
    v_valid = '0;
    mode = M_DROP;

    // Reset during ACCESS drops the transfer; request retries afterwards
    do_reset();
    set_req(0, 1'b0, 5'h03, '0, 1'b0);
    tick(a0, a1);
    tick(a0, a1);
    check("mid_in_access", {penable, ack0}, 2'b11);
    do_reset();
    run(1, 10);
    check("mid_retry_id", order[0], 0);

    // Lock: read with lock then write without lock while requester 1 waits
    do_reset();
    mode = M_LOCK;
    seq0 = 0;
    set_req(0, 1'b0, 5'h10, '0, 1'b1);
    set_req(1, 1'b1, 5'h00, 32'h0000_00FF, 1'b0);
    run(3, 40);
    exp_o[0] = 0;
    exp_o[1] = LOCK_EN ? 0 : 1;
    exp_o[2] = LOCK_EN ? 1 : 0;
    for (int i = 0; i < 3; i++) check("lock_order", order[i], exp_o[i]);
    v_valid = '0;
    mode = M_DROP;

    // Random traffic, including valid dropped mid-transfer
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      tick(a0, a1);
      if (a0) v_valid[0] = 1'b0;
      if (a1) v_valid[1] = 1'b0;
      for (int n = 0; n < 2; n++) begin
        if (m_act && m_win == n && cyc == m_s) begin
          if ($urandom_range(7, 0) == 0) v_valid[n] = 1'b0;
        end else if (!(m_act && m_win == n && cyc == m_s + 1) && !v_valid[n]
                     && $urandom_range(1, 0) == 1) begin
          set_req(n, 1'($urandom_range(1, 0)), AW'($urandom), DW'($urandom),
                  $urandom_range(3, 0) == 0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
